uart_rx_param: RTL and testbench

// - Parametrised UART receive engine; the next generation of the 16750 receiver.
// - Configurable oversampling and maximum word length.
// - 3-sample majority vote per bit.
// - Word length selected at runtime from 5 to MAX_DATA bits; stick parity supported.
// - Sits between the baud generator (RXCLK tick) and the RX FIFO. Output is one registered

---
 rtl/uart_rx_param.sv | 187 ++++++++++++++++++
 tb/tb_uart_rx_param.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampled UART receive engine with 3-sample majority vote, runtime word
// length, stick parity and a registered valid/ready word. Define UART_RX_TIMEOUT_EN for TIMEOUT.
module uart_rx_param #(
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned MAX_DATA    = 9,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                CLK,
  input  logic                RSTN,
  input  logic                RXCLK,
  input  logic                RXCLEAR,
  input  logic [3:0]          DLEN,
  input  logic                PEN,
  input  logic                EPS,
  input  logic                SP,
  input  logic                SIN,
  output logic [MAX_DATA-1:0] DOUT,
  output logic                DVALID,
  input  logic                DREADY,
  output logic                PE,
  output logic                FE,
  output logic                BI,
  output logic                OE,
  output logic                TIMEOUT
);

  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] T_PRE  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2);
  localparam logic [TW-1:0] T_POST = TW'(OVERSAMPLE / 2 + 1);
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [3:0]    LEN_MAX = 4'(MAX_DATA);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BRKW} state_t;

  state_t                state, stateNext;
  logic [SYNC_STAGES-1:0] syncQ;
  logic                  sSin;
  logic [TW-1:0]         tickCnt;
  logic                  atPre, atMid, atPost, atLast;
  logic                  v0, v1, voteBit;
  logic [3:0]            dlenEff, bitCnt;
  logic [MAX_DATA-1:0]   dataReg;
  logic                  parBit;
  logic                  shiftEn, parEn, complete;
  logic                  peCalc, feCalc, biCalc;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) syncQ <= '1;
    else       syncQ <= {syncQ[SYNC_STAGES-2:0], SIN};
  end
  assign sSin = syncQ[SYNC_STAGES-1];

  assign atPre   = RXCLK && (tickCnt == T_PRE);
  assign atMid   = RXCLK && (tickCnt == T_MID);
  assign atPost  = RXCLK && (tickCnt == T_POST);
  assign atLast  = RXCLK && (tickCnt == T_LAST);
  assign voteBit = (v0 & v1) | (v0 & sSin) | (v1 & sSin);

  always_comb begin
    dlenEff = DLEN;
    if (DLEN < 4'd5)         dlenEff = 4'd5;
    else if (DLEN > LEN_MAX) dlenEff = LEN_MAX;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:  if (!sSin) stateNext = START;
      START: if (atMid && sSin) stateNext = IDLE;
             else if (atLast) stateNext = DATA;
      DATA:  if (atLast && bitCnt >= dlenEff) stateNext = PEN ? PAR : STOP;
      PAR:   if (atLast) stateNext = STOP;
      STOP:  if (atPost) stateNext = voteBit ? IDLE : BRKW;
      BRKW:  if (sSin) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    if (RXCLEAR) stateNext = IDLE;
  end

  always_comb begin
    shiftEn  = (state == DATA) && atPost && !RXCLEAR;
    parEn    = (state == PAR)  && atPost && !RXCLEAR;
    complete = (state == STOP) && atPost && !RXCLEAR;
  end

  // Counter restarts on every state change, so DATA entry at the START wrap lines up with bit 0.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN)                                  tickCnt <= '0;
    else if (stateNext != state || state == IDLE) tickCnt <= '0;
    else if (RXCLK)                             tickCnt <= (tickCnt == T_LAST) ? '0 : tickCnt + TW'(1);
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      v0 <= 1'b1;
      v1 <= 1'b1;
    end else begin
      if (atPre) v0 <= sSin;
      if (atMid) v1 <= sSin;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      dataReg <= '0;
      bitCnt  <= '0;
      parBit  <= 1'b0;
    end else if (state == START) begin
      dataReg <= '0;
      bitCnt  <= '0;
      parBit  <= 1'b0;
    end else begin
      if (shiftEn) begin
        for (int unsigned i = 0; i < MAX_DATA; i++)
          if (4'(i) == bitCnt) dataReg[i] <= voteBit;
        bitCnt <= bitCnt + 4'd1;
      end
      if (parEn) parBit <= voteBit;
    end
  end

  always_comb begin
    peCalc = 1'b0;
    if (PEN) peCalc = SP ? (parBit != ~EPS) : ((^dataReg) ^ parBit ^ ~EPS);
    feCalc = ~voteBit;
    biCalc = feCalc && (dataReg == '0) && (!PEN || !parBit);
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      DOUT   <= '0;
      DVALID <= 1'b0;
      PE     <= 1'b0;
      FE     <= 1'b0;
      BI     <= 1'b0;
      OE     <= 1'b0;
    end else if (RXCLEAR) begin
      DVALID <= 1'b0;
      OE     <= 1'b0;
    end else begin
      OE <= 1'b0;
      if (complete) begin
        if (!DVALID || DREADY) begin
          DOUT   <= dataReg;
          PE     <= peCalc;
          FE     <= feCalc;
          BI     <= biCalc;
          DVALID <= 1'b1;
        end else begin
          OE <= 1'b1;
        end
      end else if (DVALID && DREADY) begin
        DVALID <= 1'b0;
      end
    end
  end

`ifdef UART_RX_TIMEOUT_EN
  logic [15:0] toCnt, toLimit;
  logic        leaveIdle;

  assign leaveIdle = (state == IDLE) && (stateNext != IDLE);
  assign toLimit   = (({12'd0, dlenEff} + 16'd2 + {15'd0, PEN}) * 16'(OVERSAMPLE)) << 2;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      toCnt   <= '0;
      TIMEOUT <= 1'b0;
    end else if (RXCLEAR || complete || (DVALID && DREADY) || leaveIdle) begin
      toCnt   <= '0;
      TIMEOUT <= 1'b0;
    end else if (RXCLK && DVALID && state == IDLE && !TIMEOUT) begin
      toCnt <= toCnt + 16'd1;
      if (toCnt + 16'd1 == toLimit) TIMEOUT <= 1'b1;
    end
  end
`else
  assign TIMEOUT = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: directed frames against uart_rx_param (OVERSAMPLE=16, RXCLK every 4 CLK).
module tb_uart_rx_param;
  localparam int BIT_CLKS = 64;

  logic       CLK = 1'b0;
  logic       RSTN, RXCLK = 1'b0, RXCLEAR, DREADY, PEN, EPS, SP, SIN;
  logic [3:0] DLEN;
  logic [8:0] DOUT;
  logic       DVALID, PE, FE, BI, OE, TIMEOUT;

  int checks = 0, failures = 0;
  int rxDiv = 0;
  int wordCnt = 0, validCycles = 0, oeCnt = 0, ticksSeen = 0, capTicks = 0;
  int baseW, baseV, baseO, target;
  logic       prevValid = 1'b0;
  logic [8:0] capDout = '0;
  logic       capPe = 1'b0, capFe = 1'b0, capBi = 1'b0;

  uart_rx_param #(.OVERSAMPLE(16), .MAX_DATA(9), .SYNC_STAGES(2)) dut (
    .CLK(CLK), .RSTN(RSTN), .RXCLK(RXCLK), .RXCLEAR(RXCLEAR), .DLEN(DLEN), .PEN(PEN),
    .EPS(EPS), .SP(SP), .SIN(SIN), .DOUT(DOUT), .DVALID(DVALID), .DREADY(DREADY),
    .PE(PE), .FE(FE), .BI(BI), .OE(OE), .TIMEOUT(TIMEOUT)
  );

  always #5 CLK = ~CLK;

  initial begin
    forever begin
      @(negedge CLK);
      RXCLK = (rxDiv == 3);
      rxDiv = (rxDiv + 1) % 4;
    end
  end

  always @(posedge CLK) if (RXCLK) ticksSeen <= ticksSeen + 1;

  always @(negedge CLK) begin
    if (DVALID && !prevValid) begin
      wordCnt++;
      capDout  = DOUT;
      capPe    = PE;
      capFe    = FE;
      capBi    = BI;
      capTicks = ticksSeen;
    end
    if (DVALID) validCycles++;
    if (OE) oeCnt++;
    prevValid = DVALID;
  end

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic holdBit(input logic b, input logic spike);
    SIN = b;
    if (spike) begin
      repeat (36) @(negedge CLK);
      SIN = 1'b0;
      repeat (4) @(negedge CLK);
      SIN = b;
      repeat (BIT_CLKS - 40) @(negedge CLK);
    end else begin
      repeat (BIT_CLKS) @(negedge CLK);
    end
  endtask

  task automatic sendFrame(input logic [8:0] d, input int n, input logic usePar,
                           input logic parBit, input logic stopBit, input int spikeAt);
    holdBit(1'b0, 1'b0);
    for (int i = 0; i < n; i++) holdBit(d[i], i == spikeAt);
    if (usePar) holdBit(parBit, 1'b0);
    holdBit(stopBit, 1'b0);
    SIN = 1'b1;
  endtask

  task automatic idleBits(input int n);
    SIN = 1'b1;
    repeat (n * BIT_CLKS) @(negedge CLK);
  endtask

  initial begin
    RSTN = 1'b0; RXCLEAR = 1'b0; DREADY = 1'b1; DLEN = 4'd8;
    PEN = 1'b0; EPS = 1'b0; SP = 1'b0; SIN = 1'b1;
    repeat (3) @(negedge CLK);
    checkEq("rst_dout", 32'(DOUT), 32'h0);
    checkEq("rst_dvalid", 32'(DVALID), 32'h0);
    checkEq("rst_flags", {29'd0, PE, FE, BI}, 32'h0);
    checkEq("rst_oe", 32'(OE), 32'h0);
    checkEq("rst_timeout", 32'(TIMEOUT), 32'h0);
    RSTN = 1'b1;
    idleBits(1);

    // 8N1 0x5A with DREADY held high
    baseW = wordCnt; baseV = validCycles;
    sendFrame(9'h05A, 8, 1'b0, 1'b0, 1'b1, -1);
    idleBits(2);
    checkEq("t1_words", 32'(wordCnt - baseW), 32'd1);
    checkEq("t1_dout", 32'(capDout), 32'h5A);
    checkEq("t1_vcycles", 32'(validCycles - baseV), 32'd1);
    checkEq("t1_flags", {29'd0, capPe, capFe, capBi}, 32'h0);
    checkEq("t1_dvalid_low", 32'(DVALID), 32'h0);

    // 7E1 0x41 with wrong parity, then stick parity
    DLEN = 4'd7; PEN = 1'b1; EPS = 1'b1; SP = 1'b0;
    sendFrame(9'h041, 7, 1'b1, 1'b1, 1'b1, -1);
    idleBits(2);
    checkEq("t2_pe_bad", 32'(capPe), 32'h1);
    checkEq("t2_dout", 32'(capDout), 32'h41);
    checkEq("t2_fe", 32'(capFe), 32'h0);
    SP = 1'b1; EPS = 1'b0;
    sendFrame(9'h041, 7, 1'b1, 1'b1, 1'b1, -1);
    idleBits(2);
    checkEq("t2_stick_ok", 32'(capPe), 32'h0);
    sendFrame(9'h041, 7, 1'b1, 1'b0, 1'b1, -1);
    idleBits(2);
    checkEq("t2_stick_bad", 32'(capPe), 32'h1);

    // DLEN clamping at both ends
    SP = 1'b0; PEN = 1'b0; DLEN = 4'd3;
    sendFrame(9'h015, 5, 1'b0, 1'b0, 1'b1, -1);
    idleBits(2);
    checkEq("dlen_min", 32'(capDout), 32'h15);
    DLEN = 4'd15;
    sendFrame(9'h1A5, 9, 1'b0, 1'b0, 1'b1, -1);
    idleBits(2);
    checkEq("dlen_max", 32'(capDout), 32'h1A5);
    DLEN = 4'd8;

    // Break: line low for 12 bit times
    baseW = wordCnt;
    SIN = 1'b0;
    repeat (12 * BIT_CLKS) @(negedge CLK);
    idleBits(4);
    checkEq("t3_words", 32'(wordCnt - baseW), 32'd1);
    checkEq("t3_dout", 32'(capDout), 32'h0);
    checkEq("t3_fe_bi", {30'd0, capFe, capBi}, 32'h3);
    checkEq("t3_pe", 32'(capPe), 32'h0);
    sendFrame(9'h033, 8, 1'b0, 1'b0, 1'b1, -1);
    idleBits(2);
    checkEq("t3_after", 32'(wordCnt - baseW), 32'd2);
    checkEq("t3_after_dout", {23'd0, capDout}, {23'd0, 9'h033});

    // Overrun: two words, consumer stalled
    DREADY = 1'b0;
    baseW = wordCnt; baseO = oeCnt;
    sendFrame(9'h011, 8, 1'b0, 1'b0, 1'b1, -1);
    idleBits(1);
    sendFrame(9'h022, 8, 1'b0, 1'b0, 1'b1, -1);
    idleBits(2);
    checkEq("t4_oe_pulse", 32'(oeCnt - baseO), 32'd1);
    checkEq("t4_dout_kept", 32'(DOUT), 32'h11);
    checkEq("t4_dvalid", 32'(DVALID), 32'h1);
    checkEq("t4_words", 32'(wordCnt - baseW), 32'd1);
    DREADY = 1'b1;
    @(negedge CLK);
    checkEq("t4_dvalid_fall", 32'(DVALID), 32'h0);
    idleBits(1);

    // False start and mid-bit spike
    baseW = wordCnt;
    SIN = 1'b0;
    repeat (16) @(negedge CLK);
    idleBits(3);
    checkEq("t5_false_start", 32'(wordCnt - baseW), 32'd0);
    sendFrame(9'h0FF, 8, 1'b0, 1'b0, 1'b1, 3);
    idleBits(2);
    checkEq("t5_spike_words", 32'(wordCnt - baseW), 32'd1);
    checkEq("t5_spike_dout", 32'(capDout), 32'hFF);

    // Character timeout on an unread word
    DREADY = 1'b0;
    sendFrame(9'h05A, 8, 1'b0, 1'b0, 1'b1, -1);
    target = capTicks + 639;
    for (int i = 0; i < 4000 && ticksSeen < target; i++) @(negedge CLK);
    checkEq("t6_wait639", 32'(ticksSeen), 32'(target));
    checkEq("t6_to_before", 32'(TIMEOUT), 32'h0);
    target = capTicks + 640;
    for (int i = 0; i < 100 && ticksSeen < target; i++) @(negedge CLK);
    checkEq("t6_wait640", 32'(ticksSeen), 32'(target));
`ifdef UART_RX_TIMEOUT_EN
    checkEq("t6_to_set", 32'(TIMEOUT), 32'h1);
`else
    checkEq("t6_to_tied", 32'(TIMEOUT), 32'h0);
`endif
    DREADY = 1'b1;
    @(negedge CLK);
    checkEq("t6_to_clear", 32'(TIMEOUT), 32'h0);
    checkEq("t6_dvalid_clear", 32'(DVALID), 32'h0);
    idleBits(1);

    // RXCLEAR in the middle of DATA with a word held
    DREADY = 1'b0;
    sendFrame(9'h077, 8, 1'b0, 1'b0, 1'b1, -1);
    idleBits(1);
    checkEq("clr_held", 32'(DVALID), 32'h1);
    baseW = wordCnt;
    holdBit(1'b0, 1'b0);
    SIN = 1'b1;
    repeat (3 * BIT_CLKS + 20) @(negedge CLK);
    RXCLEAR = 1'b1;
    @(negedge CLK);
    RXCLEAR = 1'b0;
    checkEq("clr_dvalid", 32'(DVALID), 32'h0);
    idleBits(12);
    checkEq("clr_no_word", 32'(wordCnt - baseW), 32'd0);
    checkEq("clr_dvalid_after", 32'(DVALID), 32'h0);
    checkEq("clr_oe", 32'(OE), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
